serial_adder_ctrl: RTL and testbench

- Controller that sequences one 1-bit adder cell (two half-adder cells plus OR) over a WIDTH-bit operand pair, LSB first.
- Produces a WIDTH-bit sum and carry-out under a start/busy/done handshake.
- Sits beside the combinational adder cells as the first sequential user of them.
- Trades latency for area; the cell is shared across all bit positions.

---
 rtl/serial_adder_ctrl_pkg.sv | 19 +
 rtl/serial_adder_ctrl_fa_cell.sv | 40 ++++
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the legal operand-width range.
package serial_adder_ctrl_pkg;

    // Encoding 2'd3 is unused and steers the FSM back to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder assembled from two half-adder cells and an OR,
// shared by the serial controller across every bit position.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s_first;
    logic c_first;
    logic c_second;

    ha_cell u_ha_ab (
        .a (a),
        .b (b),
        .s (s_first),
        .c (c_first)
    );

    // Second stage folds in the incoming carry; at most one stage can carry.
    ha_cell u_ha_cin (
        .a (s_first),
        .b (cin),
        .s (s),
        .c (c_second)
    );

    assign cout = c_first | c_second;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell walks a WIDTH-bit operand pair
// LSB first under a start/busy/done handshake, yielding sum and carry-out.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic             cell_s;
    logic             cell_c;

    fa_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start is only looked at in IDLE/DONE, so an unknown start mid-run is harmless.
    always_comb begin
        state_next = ST_IDLE;
        load       = 1'b0;
        step       = 1'b0;
        last       = (cnt == LAST_BIT);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step       = 1'b1;
                state_next = last ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
            carry  <= cell_c;
            cnt    <= last ? '0 : cnt + CW'(1);
        end
    end

    // Result registers change only on the final bit, keeping the previous
    // answer readable through idle time and the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (step && last) begin
            sum_q  <= {cell_s, sum_sh[WIDTH-1:1]};
            cout_q <= cell_c;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH 8, 2 and 32: directed
// vector table, handshake corner sequences, and random pairs against a+b.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        start8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start2, busy2, done2, cout2;
    logic [1:0]  a2, b2, sum2;
    logic        start32, busy32, done32, cout32;
    logic [31:0] a32, b32, sum32;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk), .rst (rst), .start (start8), .a (a8), .b (b8),
        .busy (busy8), .done (done8), .sum (sum8), .cout (cout8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk (clk), .rst (rst), .start (start2), .a (a2), .b (b2),
        .busy (busy2), .done (done2), .sum (sum2), .cout (cout2)
    );

    serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk (clk), .rst (rst), .start (start32), .a (a32), .b (b32),
        .busy (busy32), .done (done32), .sum (sum32), .cout (cout32)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[8];

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic getDone(input int w);
        case (w)
            2:       return done2;
            32:      return done32;
            default: return done8;
        endcase
    endfunction

    function automatic logic getBusy(input int w);
        case (w)
            2:       return busy2;
            32:      return busy32;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [63:0] getResult(input int w);
        case (w)
            2:       return {61'd0, cout2, sum2};
            32:      return {31'd0, cout32, sum32};
            default: return {55'd0, cout8, sum8};
        endcase
    endfunction

    task automatic applyStimulus(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
        case (w)
            2: begin
                start2 = s;
                a2     = a[1:0];
                b2     = b[1:0];
            end
            32: begin
                start32 = s;
                a32     = a;
                b32     = b;
            end
            default: begin
                start8 = s;
                a8     = a[7:0];
                b8     = b[7:0];
            end
        endcase
    endtask

    // Single start pulse; returns at the falling edge inside the DONE cycle.
    task automatic runOp(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name);
        int n;
        int busyCycles;
        @(negedge clk);
        applyStimulus(w, 1'b1, a, b);
        @(negedge clk);
        applyStimulus(w, 1'b0, a, b);
        n          = 1;
        busyCycles = 0;
        while (getDone(w) !== 1'b1 && n <= 3 * w + 10) begin
            if (getBusy(w) === 1'b1) busyCycles++;
            @(negedge clk);
            n++;
        end
        checkOutput({name, " latency"}, 64'(n), 64'(w + 1));
        checkOutput({name, " busy cycles"}, 64'(busyCycles), 64'(w));
        checkOutput({name, " result"}, getResult(w), exp);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int          n;
        int          doneSeen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] mask;
        logic [63:0] expSum;

        vecs[0] = '{8'h3C, 8'h05, 8'h41, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[6] = '{8'h01, 8'h02, 8'h03, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};

        rst = 1'b1;
        applyStimulus(8, 1'b0, 32'd0, 32'd0);
        applyStimulus(2, 1'b0, 32'd0, 32'd0);
        applyStimulus(32, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: everything quiet and zero.
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("idle8 cycle %0d", i), {60'd0, busy8, done8, cout8, 1'b0} | 64'(sum8), 64'd0);
            @(negedge clk);
        end
        checkOutput("reset w2", {busy2, done2, cout2, sum2}, 64'd0);
        checkOutput("reset w32", {busy32, done32, cout32, sum32}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            runOp(8, 32'(vecs[i].a), 32'(vecs[i].b), {55'd0, vecs[i].cout, vecs[i].sum},
                  $sformatf("vec%0d", i));
        end
        @(negedge clk);
        checkOutput("done single pulse", {63'd0, done8}, 64'd0);
        checkOutput("result held in idle", getResult(8), 64'h080);

        // Start pulse with new operands in RUN cycle 3 and an unknown start in
        // cycle 4 must both be ignored.
        applyStimulus(8, 1'b1, 32'h10, 32'h20);
        @(negedge clk);
        applyStimulus(8, 1'b0, 32'h10, 32'h20);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(8, 1'b1, 32'hFF, 32'hFF);
        checkOutput("prev result held in run", getResult(8), 64'h080);
        @(negedge clk);
        applyStimulus(8, 1'bx, 32'hFF, 32'hFF);
        @(negedge clk);
        applyStimulus(8, 1'b0, 32'hFF, 32'hFF);
        n = 5;
        while (done8 !== 1'b1 && n <= 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ignored start latency", 64'(n), 64'd9);
        checkOutput("ignored start result", getResult(8), 64'h030);
        @(negedge clk);
        checkOutput("ignored start back idle", {62'd0, busy8, done8}, 64'd0);

        // Reset in RUN cycle 4 aborts without a done pulse.
        applyStimulus(8, 1'b1, 32'h3C, 32'h05);
        @(negedge clk);
        applyStimulus(8, 1'b0, 32'h3C, 32'h05);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort state", {60'd0, busy8, done8, cout8, 1'b0} | 64'(sum8), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 === 1'b1) doneSeen++;
            @(negedge clk);
        end
        checkOutput("abort no done", 64'(doneSeen), 64'd0);
        checkOutput("abort result cleared", getResult(8), 64'd0);

        // start held high: back-to-back launches every WIDTH+1 cycles.
        applyStimulus(8, 1'b1, 32'h01, 32'h02);
        @(negedge clk);
        applyStimulus(8, 1'b1, 32'h7F, 32'h01);
        n = 1;
        while (done8 !== 1'b1 && n <= 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held start first latency", 64'(n), 64'd9);
        checkOutput("held start first result", getResult(8), 64'h003);
        @(negedge clk);
        n = 1;
        while (done8 !== 1'b1 && n <= 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held start period", 64'(n), 64'd9);
        checkOutput("held start second result", getResult(8), 64'h080);
        applyStimulus(8, 1'b0, 32'h00, 32'h00);
        @(negedge clk);
        checkOutput("held start released", {62'd0, busy8, done8}, 64'd0);

        // Random pairs at each width against an exact a+b model.
        foreach (vecs[k]) begin end
        for (int wi = 0; wi < 3; wi++) begin
            int w;
            w    = (wi == 0) ? 8 : (wi == 1) ? 2 : 32;
            mask = (64'd1 << w) - 64'd1;
            for (int i = 0; i < 1000; i++) begin
                ra     = $urandom;
                rb     = $urandom;
                expSum = ({32'd0, ra} & mask) + ({32'd0, rb} & mask);
                runOp(w, ra, rb, expSum, $sformatf("rand w%0d #%0d", w, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
